// File: rtl/multi_zone_clock.sv
// Multi-zone BCD wall clock with per-zone hour offsets and 12h/24h display.
// Ports: clk_1k/clr_sw_n, five level buttons, BCD time, zone and day outputs.
module multi_zone_clock #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int N_ZONES       = 4,
    parameter int ZW            = $clog2(N_ZONES)
) (
    input  logic          clk_1k,
    input  logic          clr_sw_n,
    input  logic          btn_hour_inc,
    input  logic          btn_min_inc,
    input  logic          btn_zone_next,
    input  logic          btn_ofs_inc,
    input  logic          btn_mode,
    output logic [7:0]    disp_hour,
    output logic [7:0]    disp_min,
    output logic [7:0]    disp_sec,
    output logic          pm,
    output logic          mode_12h,
    output logic [ZW-1:0] zone_idx,
    output logic [4:0]    zone_ofs,
    output logic [1:0]    day_adj,
    output logic          sec_tick
);

    localparam logic [15:0] TERM = 16'(TICKS_PER_SEC - 1);

    // Offsets are 5-bit two's complement hours
    localparam logic [4:0] OFS_MAX = 5'd14;
    localparam logic [4:0] OFS_MIN = 5'b10100;

    // Button bit order: {mode, ofs, zone, min, hour}
    logic [4:0]    btn_now;
    logic [4:0]    btn_prev_q;
    logic [4:0]    press;

    logic [15:0]   presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [ZW-1:0] zone_q, zone_d;
    logic          mode_q, mode_d;
    logic [4:0]    ofs_q [N_ZONES];
    logic [4:0]    ofs_d [N_ZONES];

    logic          tick;
    logic          hour_carry;
    logic [1:0]    hour_inc;
    logic [5:0]    hsum;

    logic [4:0]    ofs_sel;
    logic [6:0]    lsum;
    logic [4:0]    lhour;
    logic [1:0]    day_d;
    logic [4:0]    shown_hr;
    logic          pm_d;

    logic [7:0]    disp_hour_q;
    logic [7:0]    disp_min_q;
    logic [7:0]    disp_sec_q;
    logic          pm_q;
    logic          mode_out_q;
    logic [ZW-1:0] zone_out_q;
    logic [4:0]    zone_ofs_q;
    logic [1:0]    day_adj_q;
    logic          sec_tick_q;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = v / 6'd10;
        u = v % 6'd10;
        return {t[3:0], u[3:0]};
    endfunction

    assign btn_now = {btn_mode, btn_ofs_inc, btn_zone_next,
                      btn_min_inc, btn_hour_inc};
    assign press   = btn_now & ~btn_prev_q;
    assign tick    = (presc_q == TERM);

    // Time-of-day next state
    always_comb begin
        presc_d    = presc_q + 16'd1;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_carry = 1'b0;
        if (press[1]) begin
            // Minute set wins over a tick and never carries into the hour
            min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            sec_d   = 6'd0;
            presc_d = 16'd0;
        end else if (tick) begin
            presc_d = 16'd0;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d      = 6'd0;
                    hour_carry = 1'b1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        // Tick carry and an hour press can both land in one cycle
        hour_inc = {1'b0, hour_carry} + {1'b0, press[0]};
        hsum     = {1'b0, hour_q} + {4'd0, hour_inc};
        hour_d   = (hsum >= 6'd24) ? 5'(hsum - 6'd24) : hsum[4:0];
    end

    // Zone, offset and mode next state
    always_comb begin
        mode_d = mode_q ^ press[4];
        zone_d = zone_q;
        if (press[2]) begin
            zone_d = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + ZW'(1);
        end
        ofs_d = ofs_q;
        // Uses the pre-switch zone; zone 0 stays pinned at zero
        if (press[3] && (zone_q != '0)) begin
            ofs_d[zone_q] = (ofs_q[zone_q] == OFS_MAX) ?
                            OFS_MIN : ofs_q[zone_q] + 5'd1;
        end
    end

    // Local hour and display formatting from current state
    always_comb begin
        ofs_sel = ofs_q[zone_q];
        lsum    = {2'b00, hour_q} + {{2{ofs_sel[4]}}, ofs_sel};
        if ($signed(lsum) > 7'sd23) begin
            lhour = 5'(lsum - 7'd24);
            day_d = 2'b01;
        end else if (lsum[6]) begin
            lhour = 5'(lsum + 7'd24);
            day_d = 2'b11;
        end else begin
            lhour = lsum[4:0];
            day_d = 2'b00;
        end
        shown_hr = lhour;
        pm_d     = 1'b0;
        if (mode_q) begin
            pm_d = (lhour >= 5'd12);
            if (lhour == 5'd0) begin
                shown_hr = 5'd12;
            end else if (lhour > 5'd12) begin
                shown_hr = lhour - 5'd12;
            end
        end
    end

    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            btn_prev_q <= '0;
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            zone_q     <= '0;
            mode_q     <= 1'b0;
            for (int i = 0; i < N_ZONES; i++) begin
                ofs_q[i] <= '0;
            end
        end else begin
            btn_prev_q <= btn_now;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            zone_q     <= zone_d;
            mode_q     <= mode_d;
            for (int i = 0; i < N_ZONES; i++) begin
                ofs_q[i] <= ofs_d[i];
            end
        end
    end

    // Output stage trails the state by one cycle
    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            disp_hour_q <= '0;
            disp_min_q  <= '0;
            disp_sec_q  <= '0;
            pm_q        <= 1'b0;
            mode_out_q  <= 1'b0;
            zone_out_q  <= '0;
            zone_ofs_q  <= '0;
            day_adj_q   <= '0;
            sec_tick_q  <= 1'b0;
        end else begin
            disp_hour_q <= to_bcd({1'b0, shown_hr});
            disp_min_q  <= to_bcd(min_q);
            disp_sec_q  <= to_bcd(sec_q);
            pm_q        <= pm_d;
            mode_out_q  <= mode_q;
            zone_out_q  <= zone_q;
            zone_ofs_q  <= ofs_sel;
            day_adj_q   <= day_d;
            sec_tick_q  <= tick;
        end
    end

    assign disp_hour = disp_hour_q;
    assign disp_min  = disp_min_q;
    assign disp_sec  = disp_sec_q;
    assign pm        = pm_q;
    assign mode_12h  = mode_out_q;
    assign zone_idx  = zone_out_q;
    assign zone_ofs  = zone_ofs_q;
    assign day_adj   = day_adj_q;
    assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_multi_zone_clock.sv
// Directed bench for multi_zone_clock at 4 ticks/s and 4 zones.
// Inputs change and outputs are sampled on the falling edge.
module tb_multi_zone_clock;

    logic       clk_1k = 1'b0;
    logic       clr_sw_n;
    logic       btn_hour_inc, btn_min_inc, btn_zone_next;
    logic       btn_ofs_inc, btn_mode;
    logic [7:0] disp_hour, disp_min, disp_sec;
    logic       pm, mode_12h, sec_tick;
    logic [1:0] zone_idx;
    logic [4:0] zone_ofs;
    logic [1:0] day_adj;

    int total = 0;
    int bad   = 0;
    int ticks;

    localparam logic [4:0] B_HOUR = 5'b00001;
    localparam logic [4:0] B_MIN  = 5'b00010;
    localparam logic [4:0] B_ZONE = 5'b00100;
    localparam logic [4:0] B_OFS  = 5'b01000;
    localparam logic [4:0] B_MODE = 5'b10000;

    multi_zone_clock #(
        .TICKS_PER_SEC(4),
        .N_ZONES(4)
    ) dut (
        .clk_1k(clk_1k),
        .clr_sw_n(clr_sw_n),
        .btn_hour_inc(btn_hour_inc),
        .btn_min_inc(btn_min_inc),
        .btn_zone_next(btn_zone_next),
        .btn_ofs_inc(btn_ofs_inc),
        .btn_mode(btn_mode),
        .disp_hour(disp_hour),
        .disp_min(disp_min),
        .disp_sec(disp_sec),
        .pm(pm),
        .mode_12h(mode_12h),
        .zone_idx(zone_idx),
        .zone_ofs(zone_ofs),
        .day_adj(day_adj),
        .sec_tick(sec_tick)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] m);
        {btn_mode, btn_ofs_inc, btn_zone_next,
         btn_min_inc, btn_hour_inc} = m;
    endtask

    // One-cycle press then one idle cycle; returns after outputs show it
    task automatic press(input logic [4:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            set_btn(m);
            @(negedge clk_1k);
            set_btn(5'b0);
            @(negedge clk_1k);
        end
    endtask

    task automatic chk_time(input string tag, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s);
        chk({tag, "_hour"}, {24'd0, disp_hour}, {24'd0, h});
        chk({tag, "_min"}, {24'd0, disp_min}, {24'd0, m});
        chk({tag, "_sec"}, {24'd0, disp_sec}, {24'd0, s});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_time(tag, 8'h00, 8'h00, 8'h00);
        chk({tag, "_pm"}, {31'd0, pm}, 32'd0);
        chk({tag, "_mode"}, {31'd0, mode_12h}, 32'd0);
        chk({tag, "_zone"}, {30'd0, zone_idx}, 32'd0);
        chk({tag, "_ofs"}, {27'd0, zone_ofs}, 32'd0);
        chk({tag, "_day"}, {30'd0, day_adj}, 32'd0);
        chk({tag, "_tick"}, {31'd0, sec_tick}, 32'd0);
    endtask

    initial begin
        clr_sw_n = 1'b0;
        set_btn(5'b0);
        repeat (3) @(negedge clk_1k);
        chk_reset_outs("rst0");
        clr_sw_n = 1'b1;

        // 21 hour presses; 60 minute presses return min to 0 and zero secs
        press(B_HOUR, 21);
        press(B_MIN, 60);
        chk_time("h21", 8'h21, 8'h00, 8'h00);
        chk("h21_pm", {31'd0, pm}, 32'd0);

        press(B_MODE, 1);
        chk("m12_hour", {24'd0, disp_hour}, 32'h09);
        chk("m12_pm", {31'd0, pm}, 32'd1);
        chk("m12_mode", {31'd0, mode_12h}, 32'd1);
        press(B_MODE, 1);
        chk("m24_hour", {24'd0, disp_hour}, 32'h21);
        chk("m24_pm", {31'd0, pm}, 32'd0);

        press(B_ZONE, 1);
        press(B_OFS, 5);
        chk("z1_idx", {30'd0, zone_idx}, 32'd1);
        chk("z1_ofs", {27'd0, zone_ofs}, 32'd5);
        chk("z1_hour", {24'd0, disp_hour}, 32'h02);
        chk("z1_day", {30'd0, day_adj}, 32'b01);
        press(B_ZONE, 3);
        chk("z0_idx", {30'd0, zone_idx}, 32'd0);
        chk("z0_hour", {24'd0, disp_hour}, 32'h21);
        chk("z0_day", {30'd0, day_adj}, 32'b00);
        press(B_OFS, 1);
        chk("z0_pinned", {27'd0, zone_ofs}, 32'd0);

        // Zone 2: 14 steps to +14, one more wraps to -12
        press(B_ZONE, 2);
        press(B_OFS, 15);
        chk("z2_idx", {30'd0, zone_idx}, 32'd2);
        chk("z2_ofs", {27'd0, zone_ofs}, 32'h14);
        chk("z2_h21", {24'd0, disp_hour}, 32'h09);
        press(B_HOUR, 8);
        chk("z2_h05", {24'd0, disp_hour}, 32'h17);
        chk("z2_day", {30'd0, day_adj}, 32'b11);

        // 23:59 set in zone 0, then let 59 seconds elapse
        press(B_ZONE, 2);
        press(B_HOUR, 18);
        press(B_MIN, 59);
        repeat (236) @(negedge clk_1k);
        chk_time("t235959", 8'h23, 8'h59, 8'h59);
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_1k);
            if (sec_tick) ticks++;
        end
        chk_time("t000000", 8'h00, 8'h00, 8'h00);
        chk("tick_once", ticks, 32'd1);

        // Hour press aligned with the 22:59:59 rollover edge
        press(B_HOUR, 22);
        press(B_MIN, 59);
        repeat (238) @(negedge clk_1k);
        press(B_HOUR, 1);
        chk_time("both_roll", 8'h00, 8'h00, 8'h00);
        chk("both_day", {30'd0, day_adj}, 32'b00);

        // 12:34:56 in zone 1 (+5), then reset between clock edges
        press(B_ZONE, 1);
        press(B_HOUR, 12);
        press(B_MIN, 34);
        repeat (224) @(negedge clk_1k);
        chk_time("pre_rst", 8'h17, 8'h34, 8'h56);
        chk("pre_rst_ofs", {27'd0, zone_ofs}, 32'd5);
        #2 clr_sw_n = 1'b0;
        #1 chk_reset_outs("async_rst");

        @(negedge clk_1k);
        clr_sw_n = 1'b1;
        // A held button counts once
        set_btn(B_HOUR);
        repeat (3) @(negedge clk_1k);
        set_btn(5'b0);
        @(negedge clk_1k);
        chk_time("held", 8'h01, 8'h00, 8'h00);

        press(B_ZONE, 1);
        chk("post_idx", {30'd0, zone_idx}, 32'd1);
        chk("post_ofs", {27'd0, zone_ofs}, 32'd0);
        // Simultaneous zone/offset: offset goes to zone 1
        press(B_ZONE | B_OFS, 1);
        chk("sim_idx", {30'd0, zone_idx}, 32'd2);
        chk("sim_ofs", {27'd0, zone_ofs}, 32'd0);
        press(B_ZONE, 3);
        chk("sim_back_idx", {30'd0, zone_idx}, 32'd1);
        chk("sim_back_ofs", {27'd0, zone_ofs}, 32'd1);
        chk("sim_back_hour", {24'd0, disp_hour}, 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
